// File: rtl/codeword_uart_tx.sv
// Sends a 72-bit SECDED codeword as nine back-to-back UART 8N1 bytes, byte 0 (bits 7:0) first.
// Valid pulses that arrive mid-frame are dropped and flagged on overrun.
module codeword_uart_tx #(
    parameter int unsigned CLK_HZ   = 50000000,
    parameter int unsigned BIT_RATE = 9600
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [71:0] codeWord,
    input  logic        codeWordValid,
    output logic        uart_tx_pin,
    output logic        busy,
    output logic        txDone,
    output logic        overrun
);

    localparam int unsigned CLKS_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int unsigned BaudW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT < 2) begin : g_bad_rate
        $error("codeword_uart_tx: CLK_HZ / BIT_RATE must be at least 2");
    end

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e            state_q;
    logic [BaudW-1:0]  baud_q;
    logic [2:0]        bit_q;
    logic [3:0]        byte_q;
    logic [71:0]       hold_q;
    logic              tx_q;
    logic              busy_q;
    logic              done_q;
    logic              ovr_q;
    logic              armed_q;

    logic              bit_end;
    logic [2:0]        bit_sel;
    logic              next_bit;

    assign bit_end = (baud_q == BaudLast);

    // Bit that goes on the line at the next bit boundary: bit 0 when leaving START,
    // otherwise the following bit of the current byte.
    always_comb begin
        bit_sel  = (state_q == StStart) ? 3'd0 : (bit_q + 3'd1);
        next_bit = hold_q[{byte_q, bit_sel}];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            hold_q  <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            done_q  <= 1'b0;
            ovr_q   <= 1'b0;
            // The first edge after reset release never accepts a codeword.
            armed_q <= 1'b1;
            if (codeWordValid && busy_q) begin
                ovr_q <= 1'b1;
            end
            case (state_q)
                StIdle: begin
                    if (codeWordValid && !busy_q && armed_q) begin
                        hold_q  <= codeWord;
                        byte_q  <= '0;
                        bit_q   <= '0;
                        baud_q  <= '0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (bit_end) begin
                        baud_q  <= '0;
                        tx_q    <= next_bit;
                        state_q <= StData;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                StData: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (bit_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= next_bit;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                StStop: begin
                    if (bit_end) begin
                        baud_q <= '0;
                        if (byte_q == 4'd8) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            byte_q  <= byte_q + 4'd1;
                            bit_q   <= '0;
                            tx_q    <= 1'b0;
                            state_q <= StStart;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign uart_tx_pin = tx_q;
    assign busy        = busy_q;
    assign txDone      = done_q;
    assign overrun     = ovr_q;

endmodule
